// File: rtl/risc_spm_mem_if.sv
// Bus between the RISC_SPM processor and its memory unit.
// Parameter: ADDRESS_WIDTH sets the width of the address field.
// Signals:
//   address, data_in, write  - driven by the processor (master).
//   data_out, ready          - read data and clear-complete flag, driven by the memory (slave).
//   wr_count, wr_err         - saturating accepted-write count and rejected-write pulse.
interface risc_spm_mem_if #(
  parameter int unsigned ADDRESS_WIDTH = 8
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [7:0]               data_in;
  logic                     write;
  logic [7:0]               data_out;
  logic                     ready;
  logic [15:0]              wr_count;
  logic                     wr_err;

  modport master (
    output address, data_in, write,
    input  data_out, ready, wr_count, wr_err
  );

  modport slave (
    input  address, data_in, write,
    output data_out, ready, wr_count, wr_err
  );
endinterface

// File: rtl/risc_spm_mem.sv
// RISC_SPM memory unit: 2^ADDRESS_WIDTH x 8 single-port store with a registered read port.
// After reset a clearing sequencer zeroes every location, then the unit serves one access per
// cycle. Accepted writes are counted in a 16-bit saturating counter.
// Optional build macro RISC_SPM_MEM_WPROT_EN: writes to address < PROT_LIMIT are rejected and
// signalled with a one-cycle wr_err pulse; without it every address is writable, wr_err is 0.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; restarts the clear
//   bus  - slave side of risc_spm_mem_if (address/data_in/write in; data_out/ready/
//          wr_count/wr_err out)
module risc_spm_mem #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned PROT_LIMIT    = 16
) (
  input logic           clk,
  input logic           rst,
  risc_spm_mem_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                   state_d, state_q;
  logic [ADDRESS_WIDTH-1:0] init_addr_d, init_addr_q;
  logic [7:0]               mem [Depth];

  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [7:0]               mem_wdata;
  logic                     wr_accept;
  logic                     wr_reject;
  logic                     prot_hit;

  logic [7:0]               data_out_d, data_out_q;
  logic [15:0]              wr_count_d, wr_count_q;
  logic                     wr_err_d, wr_err_q;

`ifdef RISC_SPM_MEM_WPROT_EN
  // Unsigned compare; PROT_LIMIT of 0 protects nothing.
  assign prot_hit = 32'(bus.address) < PROT_LIMIT;
`else
  logic unused_prot_limit;
  assign unused_prot_limit = ^PROT_LIMIT;
  assign prot_hit          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.address;
    mem_wdata   = bus.data_in;
    wr_accept   = 1'b0;
    wr_reject   = 1'b0;
    data_out_d  = 8'h00;
    wr_count_d  = wr_count_q;
    wr_err_d    = 1'b0;

    unique case (state_q)
      StInit: begin
        // Processor writes are ignored while the sequencer owns the write port.
        mem_we      = 1'b1;
        mem_waddr   = init_addr_q;
        mem_wdata   = 8'h00;
        init_addr_d = init_addr_q + ADDRESS_WIDTH'(1);
        if (init_addr_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        wr_accept = bus.write & ~prot_hit;
        wr_reject = bus.write & prot_hit;
        mem_we    = wr_accept;
        // Write-first: a read of the address being written returns the new data.
        data_out_d = wr_accept ? bus.data_in : mem[bus.address];
        if (wr_accept && (wr_count_q != 16'hFFFF)) begin
          wr_count_d = wr_count_q + 16'd1;
        end
        wr_err_d = wr_reject;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      data_out_q  <= 8'h00;
      wr_count_q  <= 16'h0000;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      data_out_q  <= data_out_d;
      wr_count_q  <= wr_count_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Storage has no reset of its own; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = (state_q == StRun);
  assign bus.wr_count = wr_count_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_risc_spm_mem.sv
module tb_risc_spm_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  risc_spm_mem_if #(.ADDRESS_WIDTH(8)) bus ();

  risc_spm_mem #(
    .ADDRESS_WIDTH(8),
    .PROT_LIMIT   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory image plus expected registered outputs.
  logic [7:0] model_mem [256];
  logic [7:0] exp_dout   = 8'h00;
  int         exp_count  = 0;
  logic       exp_err    = 1'b0;
  int         clear_left = 256;

  function automatic bit is_prot(int a);
`ifdef RISC_SPM_MEM_WPROT_EN
    return a < 16;
`else
    return (a < 0);
`endif
  endfunction

  // One clock edge; the model advances from the inputs sampled at that edge.
  task automatic step();
    int a;
    @(posedge clk);
    if (rst) begin
      clear_left = 256;
      exp_dout   = 8'h00;
      exp_count  = 0;
      exp_err    = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_dout = 8'h00;
      exp_err  = 1'b0;
    end else begin
      a = int'(bus.address);
      if (bus.write && !is_prot(a)) begin
        model_mem[a] = bus.data_in;
        exp_dout     = bus.data_in;
        if (exp_count < 65535) exp_count++;
        exp_err = 1'b0;
      end else begin
        exp_dout = model_mem[a];
        exp_err  = bus.write;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.write = 1'b0; bus.address = 8'h5A; bus.data_in = 8'h00;
    step(); step();
    total++;
    if (bus.ready !== 1'b0 || bus.data_out !== 8'h00 || bus.wr_count !== 16'h0000 ||
        bus.wr_err !== 1'b0) begin
      $display("FAIL reset_state: ready=%b dout=%h cnt=%h err=%b want 0 00 0000 0",
               bus.ready, bus.data_out, bus.wr_count, bus.wr_err);
      bad++;
    end
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      step();
      total++;
      if (bus.ready !== (i == 256) || bus.data_out !== 8'h00) begin
        $display("FAIL clear_timing edge %0d: ready=%b dout=%h want %b 00",
                 i, bus.ready, bus.data_out, (i == 256));
        bad++;
      end
    end
    step();
    total++;
    if (bus.data_out !== 8'h00 || bus.ready !== 1'b1) begin
      $display("FAIL read_after_clear: dout=%h ready=%b want 00 1", bus.data_out, bus.ready);
      bad++;
    end
  endtask

  task automatic test_write_readback();
    bus.write = 1'b1; bus.address = 8'h40; bus.data_in = 8'hC3;
    step();
    bus.write = 1'b0; bus.data_in = 8'h00;
    step();
    total++;
    if (bus.data_out !== 8'hC3 || bus.wr_count !== 16'd1) begin
      $display("FAIL write_readback: dout=%h cnt=%h want c3 0001", bus.data_out, bus.wr_count);
      bad++;
    end
  endtask

  task automatic test_rdw();
    bus.write = 1'b1; bus.address = 8'h41; bus.data_in = 8'h7E;
    step();
    total++;
    if (bus.data_out !== 8'h7E || bus.wr_count !== 16'd2) begin
      $display("FAIL read_during_write: dout=%h cnt=%h want 7e 0002", bus.data_out, bus.wr_count);
      bad++;
    end
    bus.write = 1'b0;
  endtask

  task automatic test_init_writes();
    rst = 1'b1; bus.write = 1'b0;
    step();
    rst = 1'b0; bus.write = 1'b1; bus.address = 8'h20; bus.data_in = 8'hFF;
    for (int i = 0; i < 256; i++) step();
    bus.write = 1'b0;
    step();
    total++;
    if (bus.data_out !== 8'h00 || bus.wr_count !== 16'h0000 || bus.ready !== 1'b1) begin
      $display("FAIL init_writes_ignored: dout=%h cnt=%h ready=%b want 00 0000 1",
               bus.data_out, bus.wr_count, bus.ready);
      bad++;
    end
  endtask

  task automatic test_protect();
    bus.write = 1'b1; bus.address = 8'h0F; bus.data_in = 8'hAA;
    step();
    total++;
    if (bus.wr_err !== exp_err || bus.wr_count !== 16'(exp_count)) begin
      $display("FAIL prot_low_write: err=%b cnt=%h want %b %h",
               bus.wr_err, bus.wr_count, exp_err, 16'(exp_count));
      bad++;
    end
    bus.write = 1'b0;
    step();
    total++;
    if (bus.wr_err !== 1'b0 || bus.data_out !== exp_dout) begin
      $display("FAIL prot_low_readback: err=%b dout=%h want 0 %h",
               bus.wr_err, bus.data_out, exp_dout);
      bad++;
    end
    bus.write = 1'b1; bus.address = 8'h10; bus.data_in = 8'hAA;
    step();
    total++;
    if (bus.wr_err !== 1'b0 || bus.data_out !== 8'hAA || bus.wr_count !== 16'(exp_count)) begin
      $display("FAIL prot_edge_write: err=%b dout=%h cnt=%h want 0 aa %h",
               bus.wr_err, bus.data_out, bus.wr_count, 16'(exp_count));
      bad++;
    end
    bus.write = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.write   = ($urandom_range(0, 9) < 4);
      bus.address = 8'($urandom_range(0, 255));
      bus.data_in = 8'($urandom);
      step();
      total++;
      if (bus.data_out !== exp_dout || bus.wr_err !== exp_err ||
          bus.wr_count !== 16'(exp_count) || bus.ready !== (clear_left == 0)) begin
        $display("FAIL random cycle %0d: dout=%h err=%b cnt=%h rdy=%b want %h %b %h %b", i,
                 bus.data_out, bus.wr_err, bus.wr_count, bus.ready,
                 exp_dout, exp_err, 16'(exp_count), (clear_left == 0));
        bad++;
      end
    end
    bus.write = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.write = 1'b1; bus.address = 8'h80; bus.data_in = 8'h11;
    step();
    bus.write = 1'b0; rst = 1'b1;
    step();
    total++;
    if (bus.ready !== 1'b0 || bus.wr_count !== 16'h0000) begin
      $display("FAIL mid_reset_drop: ready=%b cnt=%h want 0 0000", bus.ready, bus.wr_count);
      bad++;
    end
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      step();
      total++;
      if (bus.ready !== (i == 256)) begin
        $display("FAIL mid_reset_clear edge %0d: ready=%b want %b", i, bus.ready, (i == 256));
        bad++;
      end
    end
    step();
    total++;
    if (bus.data_out !== 8'h00) begin
      $display("FAIL mid_reset_lost: dout=%h want 00", bus.data_out);
      bad++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 65537; i++) begin
      bus.write   = 1'b1;
      bus.address = 8'($urandom_range(16, 255));
      bus.data_in = 8'($urandom);
      step();
      if (i == 65534 || i >= 65535) begin
        total++;
        if (bus.wr_count !== 16'(exp_count) || bus.data_out !== exp_dout) begin
          $display("FAIL saturation write %0d: cnt=%h dout=%h want %h %h",
                   i, bus.wr_count, bus.data_out, 16'(exp_count), exp_dout);
          bad++;
        end
      end
    end
    bus.write = 1'b0;
    step();
    total++;
    if (bus.wr_count !== 16'hFFFF) begin
      $display("FAIL saturation_final: cnt=%h want ffff", bus.wr_count);
      bad++;
    end
  endtask

  initial begin
    bus.write   = 1'b0;
    bus.address = 8'h00;
    bus.data_in = 8'h00;
    test_reset();
    test_write_readback();
    test_rdw();
    test_init_writes();
    test_protect();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_spm_mem.md
# risc_spm_mem

Memory-unit responder for the RISC_SPM processor bus: accepts address, write data and write flag from the processor, and returns registered read data. On reset it runs a clearing sequencer that zeroes every location before it accepts traffic. It maintains a saturating count of accepted writes and can optionally enforce a write-protected low region. It sits opposite the processor on the same bus: the processor drives `address`, `data_in` and `write`, and this block drives `data_out`.

## Interface
- `ADDRESS_WIDTH`, default 8: address bits; depth = 2^ADDRESS_WIDTH words of 8 bits.
- `PROT_LIMIT`, default 16: addresses below this value are write-protected (used only with the macro).
- `clk`  input  1  single clock; everything is on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `address`  input  ADDRESS_WIDTH  read/write address from the processor.
- `data_in`  input  8  write data from the processor.
- `write`  input  1  write flag from the processor; sampled every cycle.
- `data_out`  output  8  registered read data returned to the processor.
- `ready`  output  1  high once clearing is complete and accesses are served.
- `wr_count`  output  16  saturating count of accepted writes.
- `wr_err`  output  1  one-cycle pulse when a write is rejected.

## Operation
- FSM has two states: `INIT` and `RUN`. Reset forces `INIT`.
- `INIT` (clearing):
  - `init_addr` starts at 0. Each cycle it writes 0 to `mem[init_addr]` and increments.
  - After writing address 2^ADDRESS_WIDTH-1, the FSM moves to `RUN`.
  - Processor `write` is ignored. `data_out` holds 0. `ready`=0. `wr_err`=0. `wr_count` holds.
- `RUN`:
  - A write is accepted when `write`=1 and the address is not protected. It stores `data_in` at `address` and increments `wr_count`. `wr_count` saturates at 0xFFFF.
  - Read: `data_out` <= `mem[address]` every cycle, independent of `write`.
  - Read-during-write to the same address is write-first: `data_out` returns the new `data_in`.
  - A rejected write leaves memory unchanged. `data_out` returns the old contents.
- Reset during `INIT` or `RUN` restarts the clear from address 0. All prior contents are lost.
- Reset values: `data_out`=0, `ready`=0, `wr_count`=0, `wr_err`=0, state=`INIT`, `init_addr`=0.
- Width rules:
  - `address` is used unsigned at full width; there is no wrap or aliasing.
  - The `PROT_LIMIT` compare is unsigned. `PROT_LIMIT`=0 protects nothing.

## Timing
- Read latency is 1 cycle: `address` applied in cycle N appears on `data_out` after edge N+1.
- Write commits at the edge that samples `write`=1. A read of the same address in the next cycle returns the new data.
- Clear time is exactly 2^ADDRESS_WIDTH cycles after the first edge with `rst`=0. For ADDRESS_WIDTH=8, `ready` rises after the 256th such edge.
- `wr_err` is registered: it is high for exactly the cycle after the rejected write's edge. Back-to-back rejected writes keep it high continuously.
- `wr_count` updates at the same edge as the memory write.
- The processor must not rely on data or writes before `ready`=1. There is no backpressure once `ready`=1.

## Configuration
- `RISC_SPM_MEM_WPROT_EN` defined:
  - In `RUN`, writes with `address` < `PROT_LIMIT` are rejected.
  - A rejected write pulses `wr_err` and does not increment `wr_count`.
  - `INIT` still clears protected locations.
- Macro undefined:
  - All addresses are writable and `PROT_LIMIT` is ignored.
  - `wr_err` is tied to 0.

## Test plan
- Reset then clear: assert `rst` 2 cycles, release, and read `address`=0x5A throughout. Required: `ready`=0 for 256 cycles, then 1; `data_out`=0x00 before and after.
- Write/read-back: in `RUN`, write 0xC3 to 0x40. Next cycle read 0x40: `data_out`=0xC3 one cycle later. `wr_count`=1.
- Read-during-write: `write`=1, `address`=0x41, `data_in`=0x7E. Required: `data_out`=0x7E after that edge (write-first).
- Writes during `INIT`: drive `write`=1, `address`=0x20, `data_in`=0xFF during clear. Required: after `ready`, reading 0x20 gives 0x00 and `wr_count`=0.
- Protection, with `RISC_SPM_MEM_WPROT_EN` and `PROT_LIMIT`=16:
  - Write 0xAA to 0x0F: `wr_err` is 1 for one cycle, 0x0F still reads 0x00, `wr_count` is unchanged.
  - Write 0xAA to 0x10: accepted, `wr_err`=0.
- Reset mid-operation and counter saturation:
  - After writing 0x11 to 0x80, assert `rst` mid-run. Required: `ready` drops, the 256-cycle clear reruns, and 0x80 reads 0x00.
  - Separately, perform 65,537 accepted writes. Required: `wr_count`=0xFFFF.
